// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding,
// byte/ACK constants and the device-address match helper.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    DEV_ADDR  = 4'd1,
    DEV_ACK   = 4'd2,
    REG_ADDR  = 4'd3,
    REG_ACK   = 4'd4,
    WR_DATA   = 4'd5,
    WR_ACK    = 4'd6,
    RD_FETCH  = 4'd7,
    RD_DATA   = 4'd8,
    RD_ACK    = 4'd9,
    WAIT_STOP = 4'd10
  } i2c_tgt_state_t;

  localparam int   I2C_BYTE = 8;
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Address byte carries the 7-bit device address above the R/W bit.
  function automatic logic dev_match(input logic [7:0] addr_byte, input logic [6:0] target);
    return (addr_byte[7:1] == target);
  endfunction

endpackage

// File: rtl/i2c_target_line_sync.sv
// SCL/SDA input synchronisers followed by SCL rise/fall detection and
// START/STOP condition pulses (all single-clk pulses).
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_level,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_r;
  logic [SYNC_STAGES-1:0] sda_sync_r;
  logic                   scl_prev_r;
  logic                   sda_prev_r;
  logic                   scl_now_s;
  logic                   sda_now_s;

  assign scl_now_s = scl_sync_r[SYNC_STAGES-1];
  assign sda_now_s = sda_sync_r[SYNC_STAGES-1];

  // Idle bus is high, so the chain resets to 1 to avoid a spurious edge or START.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_r <= {SYNC_STAGES{1'b1}};
      sda_sync_r <= {SYNC_STAGES{1'b1}};
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_in};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_in};
      scl_prev_r <= scl_now_s;
      sda_prev_r <= sda_now_s;
    end
  end

  assign scl_level = scl_now_s;
  assign sda_level = sda_now_s;
  assign scl_rise  = scl_now_s & ~scl_prev_r;
  assign scl_fall  = ~scl_now_s & scl_prev_r;
  assign start_det = scl_now_s & scl_prev_r & sda_prev_r & ~sda_now_s;
  assign stop_det  = scl_now_s & scl_prev_r & ~sda_prev_r & sda_now_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target decoding address/pointer/data and serving a local byte store.
// Optional clock stretching on read fetch is enabled by defining CLOCK_STRETCH_EN.
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter int         DATAWIDTH   = 8,
  parameter int         ADDRWIDTH   = 6,
  parameter logic [6:0] TARGET_ADDR = 7'h2A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 scl_in,
  input  logic                 sda_in,
  output logic                 sda_oe,
  output logic                 scl_oe,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0] mem_wdata,
  output logic                 mem_wr,
  output logic                 mem_rd,
  input  logic [DATAWIDTH-1:0] mem_rdata,
  input  logic                 mem_rvalid,
  output logic                 busy
);

  logic scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_level (scl_s),
    .sda_level (sda_s),
    .scl_rise  (scl_rise_s),
    .scl_fall  (scl_fall_s),
    .start_det (start_s),
    .stop_det  (stop_s)
  );

  i2c_tgt_state_t         state_r;
  logic [I2C_BYTE-1:0]    shift_r;
  logic [3:0]             bit_cnt_r;
  logic [ADDRWIDTH-1:0]   pointer_r;
  logic [ADDRWIDTH-1:0]   mem_addr_r;
  logic [DATAWIDTH-1:0]   mem_wdata_r;
  logic                   mem_wr_r;
  logic                   mem_rd_r;
  logic                   sda_oe_r;
  logic                   busy_r;
  logic [I2C_BYTE-1:0]    rx_byte_s;
  logic [ADDRWIDTH-1:0]   ptr_inc_s;
  logic                   scl_unused_s;

  assign rx_byte_s    = {shift_r[I2C_BYTE-2:0], sda_s};
  assign ptr_inc_s    = pointer_r + {{(ADDRWIDTH-1){1'b0}}, 1'b1};
  assign scl_unused_s = scl_s;

`ifdef CLOCK_STRETCH_EN
  logic scl_oe_r;
  assign scl_oe = scl_oe_r;
`else
  logic fetch_wait_r;
  logic rvalid_unused_s;
  assign scl_oe          = 1'b0;
  assign rvalid_unused_s = mem_rvalid;
`endif

  // Protocol FSM: ACK/data bits change on SCL fall, received bits sample on SCL rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      shift_r     <= {I2C_BYTE{1'b0}};
      bit_cnt_r   <= 4'd0;
      pointer_r   <= {ADDRWIDTH{1'b0}};
      mem_addr_r  <= {ADDRWIDTH{1'b0}};
      mem_wdata_r <= {DATAWIDTH{1'b0}};
      mem_wr_r    <= 1'b0;
      mem_rd_r    <= 1'b0;
      sda_oe_r    <= 1'b0;
      busy_r      <= 1'b0;
`ifdef CLOCK_STRETCH_EN
      scl_oe_r    <= 1'b0;
`else
      fetch_wait_r <= 1'b0;
`endif
    end else begin
      mem_wr_r <= 1'b0;
      mem_rd_r <= 1'b0;
      if (state_r != RD_FETCH) begin
`ifdef CLOCK_STRETCH_EN
        scl_oe_r <= 1'b0;
`else
        fetch_wait_r <= 1'b0;
`endif
      end
      if (stop_s) begin
        state_r  <= IDLE;
        busy_r   <= 1'b0;
        sda_oe_r <= 1'b0;
`ifdef CLOCK_STRETCH_EN
        scl_oe_r <= 1'b0;
`endif
      end else if (start_s) begin
        state_r   <= DEV_ADDR;
        bit_cnt_r <= 4'd0;
        sda_oe_r  <= 1'b0;
`ifdef CLOCK_STRETCH_EN
        scl_oe_r  <= 1'b0;
`endif
      end else begin
        case (state_r)
          IDLE: sda_oe_r <= 1'b0;
          DEV_ADDR, REG_ADDR, WR_DATA: begin
            if (scl_fall_s) begin
              sda_oe_r <= 1'b0;
            end else if (scl_rise_s) begin
              shift_r   <= rx_byte_s;
              bit_cnt_r <= bit_cnt_r + 4'd1;
              if (bit_cnt_r == 4'd7) begin
                if (state_r == DEV_ADDR) begin
                  if (dev_match(rx_byte_s, TARGET_ADDR)) begin
                    state_r <= DEV_ACK;
                    busy_r  <= 1'b1;
                  end else begin
                    state_r <= WAIT_STOP;
                    busy_r  <= 1'b0;
                  end
                end else if (state_r == REG_ADDR) begin
                  pointer_r <= rx_byte_s[ADDRWIDTH-1:0];
                  state_r   <= REG_ACK;
                end else begin
                  mem_addr_r  <= pointer_r;
                  mem_wdata_r <= rx_byte_s;
                  mem_wr_r    <= 1'b1;
                  state_r     <= WR_ACK;
                end
              end
            end
          end
          // Read fetch is launched on the ACK-clock rise so data is ready before the next fall.
          DEV_ACK, REG_ACK, WR_ACK: begin
            if (scl_fall_s) begin
              sda_oe_r <= 1'b1;
            end else if (scl_rise_s) begin
              bit_cnt_r <= 4'd0;
              if (state_r == DEV_ACK && shift_r[0]) begin
                mem_addr_r <= pointer_r;
                mem_rd_r   <= 1'b1;
                state_r    <= RD_FETCH;
              end else begin
                if (state_r == WR_ACK) begin
                  pointer_r <= ptr_inc_s;
                end
                state_r <= (state_r == DEV_ACK) ? REG_ADDR : WR_DATA;
              end
            end
          end
          RD_FETCH: begin
`ifdef CLOCK_STRETCH_EN
            if (mem_rvalid) begin
              state_r <= RD_DATA;
              if (scl_oe_r || scl_fall_s) begin
                sda_oe_r  <= ~mem_rdata[I2C_BYTE-1];
                shift_r   <= {mem_rdata[I2C_BYTE-2:0], 1'b0};
                bit_cnt_r <= 4'd1;
              end else begin
                shift_r   <= mem_rdata;
                bit_cnt_r <= 4'd0;
              end
            end else if (scl_fall_s) begin
              scl_oe_r <= 1'b1;
            end
`else
            if (fetch_wait_r) begin
              shift_r      <= mem_rdata;
              bit_cnt_r    <= 4'd0;
              fetch_wait_r <= 1'b0;
              state_r      <= RD_DATA;
            end else begin
              fetch_wait_r <= 1'b1;
            end
`endif
          end
          RD_DATA: begin
            if (scl_fall_s) begin
              if (bit_cnt_r == 4'd8) begin
                sda_oe_r <= 1'b0;
                state_r  <= RD_ACK;
              end else begin
                sda_oe_r  <= ~shift_r[I2C_BYTE-1];
                shift_r   <= {shift_r[I2C_BYTE-2:0], 1'b0};
                bit_cnt_r <= bit_cnt_r + 4'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise_s) begin
              if (sda_s == I2C_ACK) begin
                pointer_r  <= ptr_inc_s;
                mem_addr_r <= ptr_inc_s;
                mem_rd_r   <= 1'b1;
                state_r    <= RD_FETCH;
              end else begin
                state_r <= WAIT_STOP;
                busy_r  <= 1'b0;
              end
            end
          end
          WAIT_STOP: sda_oe_r <= 1'b0;
          default: begin
            state_r  <= IDLE;
            sda_oe_r <= 1'b0;
            busy_r   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_oe    = sda_oe_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_wr    = mem_wr_r;
  assign mem_rd    = mem_rd_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged controller on an open-drain bus
// plus a byte store answering the memory port. Build with CLOCK_STRETCH_EN for stretch checks.
module tb_i2c_target;

  localparam int Q     = 5;
  localparam int STALL = 20;

  logic       clk;
  logic       reset;
  logic       scl_ctrl, sda_ctrl;
  logic       scl_line, sda_line;
  logic       sda_oe, scl_oe, mem_wr, mem_rd, busy, mem_rvalid;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;

  logic [7:0] store [0:63];
  logic [5:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  logic [5:0] rd_addr_q[$];
  int n_checks, n_pass, timeouts, stretch_run, stretch_max;

  assign scl_line = scl_ctrl & ~scl_oe;
  assign sda_line = sda_ctrl & ~sda_oe;

  i2c_target dut (
    .clk        (clk),
    .reset      (reset),
    .scl_in     (scl_line),
    .sda_in     (sda_line),
    .sda_oe     (sda_oe),
    .scl_oe     (scl_oe),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wr     (mem_wr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory-port monitor and clock-stretch length tracker.
  initial begin
    stretch_run = 0;
    stretch_max = 0;
    forever begin
      @(negedge clk);
      if (mem_wr === 1'b1) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_wdata);
        store[mem_addr] = mem_wdata;
      end
      if (mem_rd === 1'b1) rd_addr_q.push_back(mem_addr);
      if (scl_oe === 1'b1) begin
        stretch_run++;
        if (stretch_run > stretch_max) stretch_max = stretch_run;
      end else begin
        stretch_run = 0;
      end
    end
  end

  // Store responder: data appears exactly one clk after the strobe (or after STALL clks).
  initial begin
    logic [5:0] a;
    forever begin
      @(negedge clk);
      if (mem_rd === 1'b1) begin
        a = mem_addr;
`ifdef CLOCK_STRETCH_EN
        repeat (STALL) @(negedge clk);
        mem_rdata  = store[a];
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = 8'h00;
`else
        @(negedge clk);
        mem_rdata = store[a];
        @(negedge clk);
        mem_rdata = 8'h00;
`endif
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    int guard;
    sda_ctrl = b;
    wait_clks(Q);
    scl_ctrl = 1'b1;
    guard = 0;
    while (scl_line !== 1'b1 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (scl_line !== 1'b1) timeouts++;
    wait_clks(Q);
    r = sda_line;
    wait_clks(Q);
    scl_ctrl = 1'b0;
    wait_clks(Q);
  endtask

  task automatic i2c_start();
    sda_ctrl = 1'b1;
    wait_clks(Q);
    scl_ctrl = 1'b1;
    wait_clks(Q);
    sda_ctrl = 1'b0;
    wait_clks(Q);
    scl_ctrl = 1'b0;
    wait_clks(Q);
  endtask

  task automatic i2c_stop();
    sda_ctrl = 1'b0;
    wait_clks(Q);
    scl_ctrl = 1'b1;
    wait_clks(Q);
    sda_ctrl = 1'b1;
    wait_clks(2 * Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic d;
    for (int i = 7; i >= 0; i--) xfer_bit(b[i], d);
    xfer_bit(1'b1, ack);
  endtask

  task automatic rd_byte(input logic ack_in, output logic [7:0] b);
    logic r;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      xfer_bit(1'b1, r);
      b = {b[6:0], r};
    end
    xfer_bit(ack_in, r);
  endtask

  task automatic clear_queues();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    wait_clks(4);
    reset = 1'b1;
    wait_clks(3);
    n_checks++; if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe: got %b want 0", sda_oe); else n_pass++;
    n_checks++; if (scl_oe !== 1'b0) $display("FAIL reset_scl_oe: got %b want 0", scl_oe); else n_pass++;
    n_checks++; if (mem_wr !== 1'b0) $display("FAIL reset_mem_wr: got %b want 0", mem_wr); else n_pass++;
    n_checks++; if (mem_rd !== 1'b0) $display("FAIL reset_mem_rd: got %b want 0", mem_rd); else n_pass++;
    n_checks++; if (mem_addr !== 6'd0) $display("FAIL reset_mem_addr: got %h want 00", mem_addr); else n_pass++;
    n_checks++; if (mem_wdata !== 8'h00) $display("FAIL reset_mem_wdata: got %h want 00", mem_wdata); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_write_single();
    logic a0, a1, a2;
    clear_queues();
    i2c_start();
    wr_byte(8'h54, a0);
    wr_byte(8'h0D, a1);
    wr_byte(8'hE5, a2);
    n_checks++; if ({a0, a1, a2} !== 3'b000) $display("FAIL wr1_acks: got %b want 000", {a0, a1, a2}); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL wr1_busy_high: got %b want 1", busy); else n_pass++;
    i2c_stop();
    n_checks++; if (busy !== 1'b0) $display("FAIL wr1_busy_stop: got %b want 0", busy); else n_pass++;
    n_checks++; if (wr_addr_q.size() !== 1) $display("FAIL wr1_count: got %0d want 1", wr_addr_q.size()); else n_pass++;
    n_checks++; if (wr_addr_q[0] !== 6'd13) $display("FAIL wr1_addr: got %0d want 13", wr_addr_q[0]); else n_pass++;
    n_checks++; if (wr_data_q[0] !== 8'hE5) $display("FAIL wr1_data: got %h want e5", wr_data_q[0]); else n_pass++;
  endtask

  task automatic test_wrap();
    logic a0, a1, a2, a3;
    clear_queues();
    i2c_start();
    wr_byte(8'h54, a0);
    wr_byte(8'h3F, a1);
    wr_byte(8'h11, a2);
    wr_byte(8'h22, a3);
    i2c_stop();
    n_checks++; if ({a0, a1, a2, a3} !== 4'b0000) $display("FAIL wrap_acks: got %b want 0000", {a0, a1, a2, a3}); else n_pass++;
    n_checks++; if (wr_addr_q.size() !== 2) $display("FAIL wrap_count: got %0d want 2", wr_addr_q.size()); else n_pass++;
    n_checks++; if (wr_addr_q[0] !== 6'd63 || wr_data_q[0] !== 8'h11) $display("FAIL wrap_first: got %0d/%h want 63/11", wr_addr_q[0], wr_data_q[0]); else n_pass++;
    n_checks++; if (wr_addr_q[1] !== 6'd0 || wr_data_q[1] !== 8'h22) $display("FAIL wrap_second: got %0d/%h want 0/22", wr_addr_q[1], wr_data_q[1]); else n_pass++;
  endtask

  task automatic test_read();
    logic a0, a1, a2;
    logic [7:0] b0, b1;
    clear_queues();
    i2c_start();
    wr_byte(8'h54, a0);
    wr_byte(8'h05, a1);
    i2c_start();
    wr_byte(8'h55, a2);
    rd_byte(1'b0, b0);
    rd_byte(1'b1, b1);
    n_checks++; if ({a0, a1, a2} !== 3'b000) $display("FAIL rd_acks: got %b want 000", {a0, a1, a2}); else n_pass++;
    n_checks++; if (b0 !== 8'h5A) $display("FAIL rd_byte0: got %h want 5a", b0); else n_pass++;
    n_checks++; if (b1 !== 8'hA5) $display("FAIL rd_byte1: got %h want a5", b1); else n_pass++;
    n_checks++; if (rd_addr_q.size() !== 2) $display("FAIL rd_count: got %0d want 2", rd_addr_q.size()); else n_pass++;
    n_checks++; if (rd_addr_q[0] !== 6'd5 || rd_addr_q[1] !== 6'd6) $display("FAIL rd_addrs: got %0d,%0d want 5,6", rd_addr_q[0], rd_addr_q[1]); else n_pass++;
    n_checks++; if (sda_oe !== 1'b0) $display("FAIL rd_nack_release: got %b want 0", sda_oe); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rd_nack_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (wr_addr_q.size() !== 0) $display("FAIL rd_no_write: got %0d want 0", wr_addr_q.size()); else n_pass++;
    i2c_stop();
  endtask

  task automatic test_wrong_addr();
    logic a0, a1;
    clear_queues();
    i2c_start();
    wr_byte(8'h56, a0);
    n_checks++; if (a0 !== 1'b1) $display("FAIL bad_addr_ack: got %b want 1", a0); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL bad_addr_busy: got %b want 0", busy); else n_pass++;
    wr_byte(8'h00, a1);
    n_checks++; if (a1 !== 1'b1) $display("FAIL bad_addr_data_ack: got %b want 1", a1); else n_pass++;
    i2c_stop();
    n_checks++; if (wr_addr_q.size() + rd_addr_q.size() !== 0) $display("FAIL bad_addr_mem: got %0d strobes want 0", wr_addr_q.size() + rd_addr_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic a0, a1, a2;
    logic [7:0] b0;
    int guard;
    i2c_start();
    wr_byte(8'h54, a0);
    wr_byte(8'h05, a1);
    i2c_start();
    wr_byte(8'h55, a2);
    guard = 0;
    while (sda_oe !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_checks++; if (sda_oe !== 1'b1) $display("FAIL rst_mid_driving: got %b want 1", sda_oe); else n_pass++;
    #3;
    reset = 1'b0;
    #1;
    n_checks++; if (sda_oe !== 1'b0 || scl_oe !== 1'b0) $display("FAIL rst_mid_async: got sda_oe=%b scl_oe=%b want 0/0", sda_oe, scl_oe); else n_pass++;
    wait_clks(3);
    sda_ctrl = 1'b1;
    wait_clks(2);
    scl_ctrl = 1'b1;
    wait_clks(STALL + 10);
    reset = 1'b1;
    wait_clks(4);
    n_checks++; if (busy !== 1'b0 || mem_addr !== 6'd0) $display("FAIL rst_mid_idle: got busy=%b addr=%0d want 0/0", busy, mem_addr); else n_pass++;
    clear_queues();
    i2c_start();
    wr_byte(8'h55, a0);
    rd_byte(1'b1, b0);
    i2c_stop();
    n_checks++; if (rd_addr_q.size() !== 1 || rd_addr_q[0] !== 6'd0) $display("FAIL rst_mid_pointer: got %0d reads at %0d want 1 at 0", rd_addr_q.size(), rd_addr_q[0]); else n_pass++;
    n_checks++; if (b0 !== 8'h22) $display("FAIL rst_mid_data: got %h want 22", b0); else n_pass++;
  endtask

  task automatic test_stretch();
    logic a0, a1, a2;
    logic [7:0] b0;
    stretch_max = 0;
    i2c_start();
    wr_byte(8'h54, a0);
    wr_byte(8'h0D, a1);
    i2c_start();
    wr_byte(8'h55, a2);
    rd_byte(1'b1, b0);
    i2c_stop();
    n_checks++; if (b0 !== 8'hE5) $display("FAIL stretch_data: got %h want e5", b0); else n_pass++;
`ifdef CLOCK_STRETCH_EN
    n_checks++; if (stretch_max < 8) $display("FAIL stretch_len: got %0d clks want >= 8", stretch_max); else n_pass++;
`else
    n_checks++; if (stretch_max !== 0) $display("FAIL stretch_off: got %0d clks want 0", stretch_max); else n_pass++;
`endif
    n_checks++; if (timeouts !== 0) $display("FAIL scl_timeout: got %0d want 0", timeouts); else n_pass++;
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    timeouts   = 0;
    reset      = 1'b0;
    scl_ctrl   = 1'b1;
    sda_ctrl   = 1'b1;
    mem_rdata  = 8'h00;
    mem_rvalid = 1'b0;
    for (int i = 0; i < 64; i++) store[i] = 8'h00;
    store[5] = 8'h5A;
    store[6] = 8'hA5;
    test_reset();
    test_write_single();
    test_wrap();
    test_read();
    test_wrong_addr();
    test_reset_mid();
    test_stretch();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
